uart_tx_arbiter: RTL

Shares the single UART transmit channel (io_dataIn_bits / io_dataIn_ready) between the manual-control byte source and the script-interpreter byte source. Today two SendData-style sources drive that channel directly and conflict; this block replaces that with one arbiter.
- Exactly one byte is in flight at a time.
- The selected byte is held stable until the UART reports completion.
- The owning requester receives a one-cycle acknowledge pulse.
- mode_script sets which requester is favoured. Bounded starvation protection and a transmit timeout keep both paths live.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the single UART transmit channel between the manual and script byte sources.
// One byte in flight at a time, held until data_ready; bounded starvation and a send timeout.
module uart_tx_arbiter #(
   parameter logic [7:0] IDLE_BYTE      = 8'h00,
   parameter int         MAX_CONSEC     = 3,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       uart_clk,
   input  logic       reset,
   input  logic       mode_script,
   input  logic       man_valid,
   input  logic [7:0] man_bits,
   output logic       man_ack,
   input  logic       scr_valid,
   input  logic [7:0] scr_bits,
   output logic       scr_ack,
   input  logic       data_ready,
   output logic [7:0] data_send,
   output logic       busy,
   output logic [1:0] owner,
   output logic       timeout_pulse,
   output logic [7:0] timeout_count
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK} state_t;

   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  MAXC      = 4'(MAX_CONSEC);
   localparam logic [1:0]  OWN_NONE  = 2'b00;
   localparam logic [1:0]  OWN_MAN   = 2'b01;
   localparam logic [1:0]  OWN_SCR   = 2'b10;

   state_t      state_q, state_d;
   logic [7:0]  data_q, data_d;
   logic [1:0]  owner_q, owner_d;
   logic        busy_q, busy_d;
   logic        man_ack_q, man_ack_d;
   logic        scr_ack_q, scr_ack_d;
   logic        tpulse_q, tpulse_d;
   logic [7:0]  tcount_q, tcount_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  consec_q, consec_d;
   logic        mode_last_q, mode_last_d;

   logic        fav_valid, oth_valid;
   logic        grant_fav, grant_oth, grant_scr;
   logic [3:0]  consec_eff;

   always_ff @(posedge uart_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         data_q      <= IDLE_BYTE;
         owner_q     <= OWN_NONE;
         busy_q      <= 1'b0;
         man_ack_q   <= 1'b0;
         scr_ack_q   <= 1'b0;
         tpulse_q    <= 1'b0;
         tcount_q    <= 8'd0;
         timer_q     <= 16'd0;
         consec_q    <= 4'd0;
         mode_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         owner_q     <= owner_d;
         busy_q      <= busy_d;
         man_ack_q   <= man_ack_d;
         scr_ack_q   <= scr_ack_d;
         tpulse_q    <= tpulse_d;
         tcount_q    <= tcount_d;
         timer_q     <= timer_d;
         consec_q    <= consec_d;
         mode_last_q <= mode_last_d;
      end
   end

   // A mode change since the last grant restarts the favoured-grant run from zero.
   always_comb begin
      fav_valid  = mode_script ? scr_valid : man_valid;
      oth_valid  = mode_script ? man_valid : scr_valid;
      consec_eff = (mode_script != mode_last_q) ? 4'd0 : consec_q;
      grant_fav  = 1'b0;
      grant_oth  = 1'b0;
      if (fav_valid && !oth_valid) begin
         grant_fav = 1'b1;
      end else if (!fav_valid && oth_valid) begin
         grant_oth = 1'b1;
      end else if (fav_valid && oth_valid) begin
         if (consec_eff < MAXC) grant_fav = 1'b1;
         else                   grant_oth = 1'b1;
      end
      grant_scr = (grant_fav && mode_script) || (grant_oth && !mode_script);
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      owner_d     = owner_q;
      busy_d      = busy_q;
      man_ack_d   = 1'b0;
      scr_ack_d   = 1'b0;
      tpulse_d    = 1'b0;
      tcount_d    = tcount_q;
      timer_d     = timer_q;
      consec_d    = consec_q;
      mode_last_d = mode_last_q;
      case (state_q)
         S_IDLE: begin
            if (grant_fav || grant_oth) begin
               state_d     = S_SEND;
               data_d      = grant_scr ? scr_bits : man_bits;
               owner_d     = grant_scr ? OWN_SCR : OWN_MAN;
               busy_d      = 1'b1;
               timer_d     = 16'd0;
               mode_last_d = mode_script;
               consec_d    = (grant_fav && oth_valid) ? consec_eff + 4'd1 : 4'd0;
            end
         end
         S_SEND: begin
            // data_ready takes priority over a timeout landing in the same cycle.
            if (data_ready) begin
               state_d   = S_ACK;
               man_ack_d = (owner_q == OWN_MAN);
               scr_ack_d = (owner_q == OWN_SCR);
            end else if (timer_q == TMO_LAST) begin
               state_d  = S_IDLE;
               data_d   = IDLE_BYTE;
               owner_d  = OWN_NONE;
               busy_d   = 1'b0;
               tpulse_d = 1'b1;
               tcount_d = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;
               timer_d  = 16'd0;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
            data_d  = IDLE_BYTE;
            owner_d = OWN_NONE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            data_d  = IDLE_BYTE;
            owner_d = OWN_NONE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign data_send     = data_q;
   assign owner         = owner_q;
   assign busy          = busy_q;
   assign man_ack       = man_ack_q;
   assign scr_ack       = scr_ack_q;
   assign timeout_pulse = tpulse_q;
   assign timeout_count = tcount_q;

endmodule
